// File: rtl/mycpu_pkg.sv
// Shared definitions for the MIPS core hazard logic: forward-select codes,
// MDU sequencer state encoding and the default register-index width.
package mycpu_pkg;

   localparam int REG_AW_DEF = 5;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'b00,
      MDU_BUSY = 2'b01,
      MDU_DONE = 2'b10
   } mduState_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Datapath <-> hazard scoreboard bundle: pipeline-stage status in, stall,
// flush and forward selects out. The datapath is master, the scoreboard slave.
interface hazard_scoreboard_if #(
   parameter int REG_AW = 5
);
   logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e;
   logic [REG_AW-1:0] write_reg_e, write_reg_m, write_reg_w;
   logic              uses_rs_d, uses_rt_d, branch_d, hilo_read_d, pcsrc_d, jump_d;
   logic              reg_write_e, reg_write_m, reg_write_w, mem_read_e, mem_read_m;
   logic              mdu_start_e, mdu_div_e, mdu_cancel;
   logic              stall_f, stall_d, stall_e, flush_d, flush_e;
   logic [1:0]        forward_ae, forward_be, forward_ad, forward_bd;
   logic              mdu_busy, mdu_done;

   modport master (
      output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
             uses_rs_d, uses_rt_d, branch_d, hilo_read_d, pcsrc_d, jump_d,
             reg_write_e, reg_write_m, reg_write_w, mem_read_e, mem_read_m,
             mdu_start_e, mdu_div_e, mdu_cancel,
      input  stall_f, stall_d, stall_e, flush_d, flush_e,
             forward_ae, forward_be, forward_ad, forward_bd, mdu_busy, mdu_done
   );

   modport slave (
      input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
             uses_rs_d, uses_rt_d, branch_d, hilo_read_d, pcsrc_d, jump_d,
             reg_write_e, reg_write_m, reg_write_w, mem_read_e, mem_read_m,
             mdu_start_e, mdu_div_e, mdu_cancel,
      output stall_f, stall_d, stall_e, flush_d, flush_e,
             forward_ae, forward_be, forward_ad, forward_bd, mdu_busy, mdu_done
   );
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer: holds E while the MDU is busy and
// pulses mduDone for the single cycle in which HI/LO are written.
module mdu_sequencer
   import mycpu_pkg::*;
#(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 6
) (
   input  logic clk,
   input  logic resetn,
   input  logic start,
   input  logic isDiv,
   input  logic cancel,
   output logic mduStall,
   output logic mduBusy,
   output logic mduDone
);

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   mduState_t        state_r, stateNext_s;
   logic [CNT_W-1:0] cnt_r, cntNext_s;

   // State and latency counter registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r <= MDU_IDLE;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= stateNext_s;
         cnt_r   <= cntNext_s;
      end
   end

   // Next-state logic; an exception cancel overrides everything, including start.
   always_comb begin
      stateNext_s = state_r;
      cntNext_s   = cnt_r;
      if (cancel) begin
         stateNext_s = MDU_IDLE;
         cntNext_s   = CNT_ZERO;
      end else begin
         case (state_r)
            MDU_IDLE: begin
               if (start) begin
                  stateNext_s = MDU_BUSY;
                  cntNext_s   = isDiv ? DIV_LOAD : MUL_LOAD;
               end else begin
                  stateNext_s = MDU_IDLE;
               end
            end
            MDU_BUSY: begin
               if (cnt_r == CNT_ZERO) begin
                  stateNext_s = MDU_DONE;
               end else begin
                  cntNext_s = cnt_r - CNT_ONE;
               end
            end
            MDU_DONE: stateNext_s = MDU_IDLE;
            default: begin
               stateNext_s = MDU_IDLE;
               cntNext_s   = CNT_ZERO;
            end
         endcase
      end
   end

   // The start cycle itself already stalls; reset forces the hold off.
   assign mduStall = resetn & (((state_r == MDU_IDLE) & start & ~cancel) |
                               (state_r == MDU_BUSY));
   assign mduBusy  = (state_r != MDU_IDLE);
   assign mduDone  = (state_r == MDU_DONE);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller for the 5-stage MIPS core: forwarding selects,
// load/branch/HI-LO interlocks, redirect flushes and the MDU E-stage hold.
module hazard_scoreboard
   import mycpu_pkg::*;
#(
   parameter int REG_AW     = REG_AW_DEF,
   parameter int MUL_LAT    = 4,
   parameter int DIV_LAT    = 32,
   parameter int CNT_W      = 6,
   parameter int FWD_W_TO_D = 1
) (
   input logic          clk,
   input logic          resetn,
   hazard_scoreboard_if.slave hz
);

   localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

   function automatic logic regMatch(input logic we, input logic [REG_AW-1:0] wr,
                                     input logic [REG_AW-1:0] src);
      return we & (wr != REG_ZERO) & (wr == src);
   endfunction

   logic mduStall_s, mduBusy_s, mduDone_s;
   logic lwStall_s, brStall_s, hiStall_s, stallD_s;
   logic useRsEMatch_s, useRtEMatch_s, useRsMMatch_s, useRtMMatch_s;
   logic [1:0] fwdAe_s, fwdBe_s, fwdAd_s, fwdBd_s;

   mdu_sequencer #(
      .MUL_LAT(MUL_LAT),
      .DIV_LAT(DIV_LAT),
      .CNT_W  (CNT_W)
   ) u_mdu (
      .clk     (clk),
      .resetn  (resetn),
      .start   (hz.mdu_start_e),
      .isDiv   (hz.mdu_div_e),
      .cancel  (hz.mdu_cancel),
      .mduStall(mduStall_s),
      .mduBusy (mduBusy_s),
      .mduDone (mduDone_s)
   );

   // Forwarding: E prefers M over W; D never forwards an in-flight load result from M.
   always_comb begin
      fwdAe_s = FWD_RF;
      fwdBe_s = FWD_RF;
      fwdAd_s = FWD_RF;
      fwdBd_s = FWD_RF;
      if (regMatch(hz.reg_write_m, hz.write_reg_m, hz.rs_e)) fwdAe_s = FWD_M;
      else if (regMatch(hz.reg_write_w, hz.write_reg_w, hz.rs_e)) fwdAe_s = FWD_W;
      else fwdAe_s = FWD_RF;
      if (regMatch(hz.reg_write_m, hz.write_reg_m, hz.rt_e)) fwdBe_s = FWD_M;
      else if (regMatch(hz.reg_write_w, hz.write_reg_w, hz.rt_e)) fwdBe_s = FWD_W;
      else fwdBe_s = FWD_RF;
      if (regMatch(hz.reg_write_m, hz.write_reg_m, hz.rs_d) && !hz.mem_read_m) fwdAd_s = FWD_M;
      else if ((FWD_W_TO_D != 0) && regMatch(hz.reg_write_w, hz.write_reg_w, hz.rs_d)) fwdAd_s = FWD_W;
      else fwdAd_s = FWD_RF;
      if (regMatch(hz.reg_write_m, hz.write_reg_m, hz.rt_d) && !hz.mem_read_m) fwdBd_s = FWD_M;
      else if ((FWD_W_TO_D != 0) && regMatch(hz.reg_write_w, hz.write_reg_w, hz.rt_d)) fwdBd_s = FWD_W;
      else fwdBd_s = FWD_RF;
   end

   assign useRsEMatch_s = hz.uses_rs_d & regMatch(hz.reg_write_e, hz.write_reg_e, hz.rs_d);
   assign useRtEMatch_s = hz.uses_rt_d & regMatch(hz.reg_write_e, hz.write_reg_e, hz.rt_d);
   assign useRsMMatch_s = hz.uses_rs_d & regMatch(hz.reg_write_m, hz.write_reg_m, hz.rs_d);
   assign useRtMMatch_s = hz.uses_rt_d & regMatch(hz.reg_write_m, hz.write_reg_m, hz.rt_d);

   assign lwStall_s = hz.mem_read_e & (hz.write_reg_e != REG_ZERO) &
                      ((hz.uses_rs_d & (hz.rs_d == hz.write_reg_e)) |
                       (hz.uses_rt_d & (hz.rt_d == hz.write_reg_e)));
   assign brStall_s = hz.branch_d & (useRsEMatch_s | useRtEMatch_s |
                      (hz.mem_read_m & (useRsMMatch_s | useRtMMatch_s)));
   assign hiStall_s = hz.hilo_read_d & (mduBusy_s | hz.mdu_start_e);
   assign stallD_s  = lwStall_s | brStall_s | hiStall_s | mduStall_s;

   // A held E is never bubbled, and a redirect only takes effect when D advances.
   assign hz.stall_e    = mduStall_s;
   assign hz.stall_d    = stallD_s;
   assign hz.stall_f    = stallD_s;
   assign hz.flush_e    = (lwStall_s | brStall_s | hiStall_s) & ~mduStall_s;
   assign hz.flush_d    = (hz.pcsrc_d | hz.jump_d) & ~stallD_s;
   assign hz.forward_ae = fwdAe_s;
   assign hz.forward_be = fwdBe_s;
   assign hz.forward_ad = fwdAd_s;
   assign hz.forward_bd = fwdBd_s;
   assign hz.mdu_busy   = mduBusy_s;
   assign hz.mdu_done   = mduDone_s;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters:
// MUL_LAT=4, DIV_LAT=32, FWD_W_TO_D=1).
module tb_hazard_scoreboard;

   logic clk;
   logic resetn;
   int   tests;
   int   fails;

   hazard_scoreboard_if #(.REG_AW(5)) hzIf();

   hazard_scoreboard dut (
      .clk   (clk),
      .resetn(resetn),
      .hz    (hzIf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clearInputs();
      hzIf.rs_d = 5'd0; hzIf.rt_d = 5'd0; hzIf.rs_e = 5'd0; hzIf.rt_e = 5'd0;
      hzIf.write_reg_e = 5'd0; hzIf.write_reg_m = 5'd0; hzIf.write_reg_w = 5'd0;
      hzIf.uses_rs_d = 1'b0; hzIf.uses_rt_d = 1'b0; hzIf.branch_d = 1'b0;
      hzIf.hilo_read_d = 1'b0; hzIf.pcsrc_d = 1'b0; hzIf.jump_d = 1'b0;
      hzIf.reg_write_e = 1'b0; hzIf.reg_write_m = 1'b0; hzIf.reg_write_w = 1'b0;
      hzIf.mem_read_e = 1'b0; hzIf.mem_read_m = 1'b0;
      hzIf.mdu_start_e = 1'b0; hzIf.mdu_div_e = 1'b0; hzIf.mdu_cancel = 1'b0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clearInputs();
      resetn = 1'b0;
      hzIf.mdu_start_e = 1'b1;
      nextCycle();
      nextCycle();
      #1;
      tests++;
      if (hzIf.mdu_busy !== 1'b0 || hzIf.mdu_done !== 1'b0) begin
         fails++;
         $display("FAIL reset_state busy=%b done=%b exp 0 0", hzIf.mdu_busy, hzIf.mdu_done);
      end
      tests++;
      if (hzIf.stall_e !== 1'b0 || hzIf.stall_d !== 1'b0) begin
         fails++;
         $display("FAIL reset_stall_forced stall_e=%b stall_d=%b exp 0 0", hzIf.stall_e, hzIf.stall_d);
      end
      hzIf.mdu_start_e = 1'b0;
      resetn = 1'b1;
      nextCycle();
   endtask

   task automatic test_lwstall();
      clearInputs();
      hzIf.mem_read_e = 1'b1; hzIf.reg_write_e = 1'b1; hzIf.write_reg_e = 5'd2;
      hzIf.rs_d = 5'd2; hzIf.uses_rs_d = 1'b1;
      #1;
      tests++;
      if ({hzIf.stall_f, hzIf.stall_d, hzIf.flush_e, hzIf.stall_e} !== 4'b1110) begin
         fails++;
         $display("FAIL lwstall_used f/d/flushE/e=%b%b%b%b exp 1110",
                  hzIf.stall_f, hzIf.stall_d, hzIf.flush_e, hzIf.stall_e);
      end
      hzIf.pcsrc_d = 1'b1;
      #1;
      tests++;
      if (hzIf.flush_d !== 1'b0) begin
         fails++;
         $display("FAIL lwstall_branch_flush_d got %b exp 0", hzIf.flush_d);
      end
      hzIf.uses_rs_d = 1'b0;
      #1;
      tests++;
      if ({hzIf.stall_d, hzIf.flush_e, hzIf.flush_d} !== 3'b001) begin
         fails++;
         $display("FAIL lwstall_unused stall_d/flush_e/flush_d=%b%b%b exp 001",
                  hzIf.stall_d, hzIf.flush_e, hzIf.flush_d);
      end
      hzIf.pcsrc_d = 1'b0;
      hzIf.uses_rs_d = 1'b1; hzIf.rs_d = 5'd0; hzIf.write_reg_e = 5'd0;
      #1;
      tests++;
      if (hzIf.stall_d !== 1'b0) begin
         fails++;
         $display("FAIL lwstall_reg0 got %b exp 0", hzIf.stall_d);
      end
      nextCycle();
   endtask

   task automatic test_branch();
      clearInputs();
      hzIf.branch_d = 1'b1; hzIf.rs_d = 5'd3; hzIf.uses_rs_d = 1'b1;
      hzIf.mem_read_e = 1'b1; hzIf.reg_write_e = 1'b1; hzIf.write_reg_e = 5'd3;
      #1;
      tests++;
      if (hzIf.stall_d !== 1'b1) begin
         fails++;
         $display("FAIL br_cycle0_stall got %b exp 1", hzIf.stall_d);
      end
      nextCycle();
      hzIf.mem_read_e = 1'b0; hzIf.reg_write_e = 1'b0; hzIf.write_reg_e = 5'd0;
      hzIf.mem_read_m = 1'b1; hzIf.reg_write_m = 1'b1; hzIf.write_reg_m = 5'd3;
      #1;
      tests++;
      if (hzIf.stall_d !== 1'b1 || hzIf.forward_ad !== 2'b00) begin
         fails++;
         $display("FAIL br_cycle1 stall_d=%b fwd_ad=%b exp 1 00", hzIf.stall_d, hzIf.forward_ad);
      end
      nextCycle();
      hzIf.mem_read_m = 1'b0; hzIf.reg_write_m = 1'b0; hzIf.write_reg_m = 5'd0;
      hzIf.reg_write_w = 1'b1; hzIf.write_reg_w = 5'd3;
      #1;
      tests++;
      if (hzIf.stall_d !== 1'b0 || hzIf.forward_ad !== 2'b01) begin
         fails++;
         $display("FAIL br_cycle2 stall_d=%b fwd_ad=%b exp 0 01", hzIf.stall_d, hzIf.forward_ad);
      end
      hzIf.reg_write_m = 1'b1; hzIf.write_reg_m = 5'd3;
      hzIf.rt_d = 5'd3; hzIf.uses_rt_d = 1'b1;
      #1;
      tests++;
      if (hzIf.stall_d !== 1'b0 || hzIf.forward_ad !== 2'b10 || hzIf.forward_bd !== 2'b10) begin
         fails++;
         $display("FAIL br_alu_in_m stall_d=%b fwd_ad=%b fwd_bd=%b exp 0 10 10",
                  hzIf.stall_d, hzIf.forward_ad, hzIf.forward_bd);
      end
      nextCycle();
   endtask

   task automatic test_forward();
      clearInputs();
      hzIf.reg_write_m = 1'b1; hzIf.write_reg_m = 5'd5;
      hzIf.reg_write_w = 1'b1; hzIf.write_reg_w = 5'd5;
      hzIf.rs_e = 5'd5; hzIf.rt_e = 5'd7;
      #1;
      tests++;
      if (hzIf.forward_ae !== 2'b10 || hzIf.forward_be !== 2'b00) begin
         fails++;
         $display("FAIL fwd_m_priority ae=%b be=%b exp 10 00", hzIf.forward_ae, hzIf.forward_be);
      end
      hzIf.reg_write_m = 1'b0; hzIf.rt_e = 5'd5;
      #1;
      tests++;
      if (hzIf.forward_ae !== 2'b01 || hzIf.forward_be !== 2'b01) begin
         fails++;
         $display("FAIL fwd_w_only ae=%b be=%b exp 01 01", hzIf.forward_ae, hzIf.forward_be);
      end
      hzIf.reg_write_m = 1'b1; hzIf.write_reg_m = 5'd0; hzIf.write_reg_w = 5'd0;
      hzIf.rs_e = 5'd0; hzIf.rt_e = 5'd0;
      #1;
      tests++;
      if (hzIf.forward_ae !== 2'b00 || hzIf.forward_be !== 2'b00) begin
         fails++;
         $display("FAIL fwd_reg0 ae=%b be=%b exp 00 00", hzIf.forward_ae, hzIf.forward_be);
      end
      nextCycle();
   endtask

   task automatic test_mdu_op(input logic isDiv, input int lat);
      int stallCnt, busyCnt, doneCnt, doneAt;
      clearInputs();
      hzIf.mdu_div_e = isDiv;
      stallCnt = 0; busyCnt = 0; doneCnt = 0; doneAt = 0;
      for (int c = 1; c <= lat + 6; c++) begin
         hzIf.mdu_start_e = (c <= lat + 2);
         #1;
         if (hzIf.stall_e === 1'b1) stallCnt++;
         if (hzIf.mdu_busy === 1'b1) busyCnt++;
         if (hzIf.mdu_done === 1'b1) begin
            doneCnt++;
            doneAt = c;
         end
         nextCycle();
      end
      tests++;
      if (stallCnt != lat + 1) begin
         fails++;
         $display("FAIL mdu_stall_len div=%b got %0d exp %0d", isDiv, stallCnt, lat + 1);
      end
      tests++;
      if (busyCnt != lat + 1 || doneCnt != 1 || doneAt != lat + 2) begin
         fails++;
         $display("FAIL mdu_busy_done div=%b busy=%0d done=%0d at=%0d exp %0d 1 %0d",
                  isDiv, busyCnt, doneCnt, doneAt, lat + 1, lat + 2);
      end
   endtask

   task automatic test_histall();
      clearInputs();
      for (int c = 1; c <= 7; c++) begin
         hzIf.mdu_start_e = (c <= 6);
         hzIf.hilo_read_d = (c >= 3);
         #1;
         tests++;
         if (hzIf.stall_d !== (c <= 6) || hzIf.flush_e !== (c == 6)) begin
            fails++;
            $display("FAIL histall_c%0d stall_d=%b flush_e=%b exp %b %b",
                     c, hzIf.stall_d, hzIf.flush_e, (c <= 6), (c == 6));
         end
         nextCycle();
      end
      clearInputs();
      nextCycle();
   endtask

   task automatic test_abort(input logic useReset);
      int doneCnt;
      clearInputs();
      hzIf.mdu_div_e = 1'b1;
      hzIf.mdu_start_e = 1'b1;
      for (int c = 1; c <= 22; c++) nextCycle();
      if (useReset) resetn = 1'b0;
      else hzIf.mdu_cancel = 1'b1;
      #1;
      tests++;
      if (hzIf.mdu_busy !== 1'b1) begin
         fails++;
         $display("FAIL abort_pre_busy rst=%b got %b exp 1", useReset, hzIf.mdu_busy);
      end
      nextCycle();
      resetn = 1'b1;
      clearInputs();
      #1;
      tests++;
      if ({hzIf.mdu_busy, hzIf.stall_e, hzIf.mdu_done} !== 3'b000) begin
         fails++;
         $display("FAIL abort_idle rst=%b busy/stall_e/done=%b%b%b exp 000",
                  useReset, hzIf.mdu_busy, hzIf.stall_e, hzIf.mdu_done);
      end
      doneCnt = 0;
      for (int c = 0; c < 12; c++) begin
         if (hzIf.mdu_done === 1'b1) doneCnt++;
         nextCycle();
      end
      tests++;
      if (doneCnt != 0) begin
         fails++;
         $display("FAIL abort_no_done rst=%b got %0d pulses exp 0", useReset, doneCnt);
      end
   endtask

   task automatic test_cancel_vs_start();
      clearInputs();
      hzIf.mdu_start_e = 1'b1;
      hzIf.mdu_cancel = 1'b1;
      #1;
      tests++;
      if (hzIf.stall_e !== 1'b0) begin
         fails++;
         $display("FAIL cancel_start_stall got %b exp 0", hzIf.stall_e);
      end
      nextCycle();
      clearInputs();
      #1;
      tests++;
      if (hzIf.mdu_busy !== 1'b0) begin
         fails++;
         $display("FAIL cancel_start_busy got %b exp 0", hzIf.mdu_busy);
      end
      nextCycle();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      resetn = 1'b0;
      clearInputs();
      test_reset();
      test_lwstall();
      test_branch();
      test_forward();
      test_mdu_op(1'b0, 4);
      test_mdu_op(1'b1, 32);
      test_histall();
      test_abort(1'b0);
      test_abort(1'b1);
      test_cancel_vs_start();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Second-generation pipeline hazard controller for the 5-stage MIPS core. Adds to the existing forwarding and interlock logic:
- source-use qualification, so instructions that do not read a register never stall on it;
- branch-after-load interlock;
- HI/LO read interlock;
- an internal multi-cycle MDU sequencer (FSM plus latency counter) that generates the E-stage hold, replacing the external MDU ready input.

Sits beside the datapath and drives all stall, flush and forward selects.

Parameters:
REG_AW, 5, register index width (2**REG_AW architectural registers; index 0 is hard-zero)
MUL_LAT, 4, MDU busy cycles for multiply (>=1)
DIV_LAT, 32, MDU busy cycles for divide (>=1)
CNT_W, 6, latency counter width; must satisfy 2**CNT_W > max(MUL_LAT,DIV_LAT)
FWD_W_TO_D, 1, 1 = W->D forwarding enabled for branch compare; 0 = M only

Ports:
clk  in  1  core clock
resetn  in  1  synchronous active-low reset
rs_d, rt_d  in  REG_AW  D-stage source indices
uses_rs_d, uses_rt_d  in  1  D instruction actually reads rs / rt
branch_d  in  1  D is a compare-in-D branch
hilo_read_d  in  1  D is mfhi/mflo
pcsrc_d, jump_d  in  1  branch taken / jump in D
rs_e, rt_e  in  REG_AW  E-stage source indices
write_reg_e, write_reg_m, write_reg_w  in  REG_AW  destination index per stage
reg_write_e, reg_write_m, reg_write_w  in  1  stage writes GPR
mem_read_e, mem_read_m  in  1  stage is a load
mdu_start_e  in  1  E holds mult/div
mdu_div_e  in  1  1 = divide, 0 = multiply
mdu_cancel  in  1  exception flush; abort MDU
stall_f, stall_d, stall_e  out  1  hold PC / IF-ID / ID-EX
flush_d, flush_e  out  1  clear IF-ID / ID-EX
forward_ae, forward_be  out  2  E operand select: 00 regfile, 10 M, 01 W
forward_ad, forward_bd  out  2  D compare select: same encoding
mdu_busy  out  1  sequencer not IDLE
mdu_done  out  1  one-cycle pulse; HI/LO written this cycle

Behaviour:
- Match rule (used below): a stage matches a source if its write_reg equals the source, write_reg != 0, and its reg_write is high.
- forward_ae/be: 10 if M matches rs_e/rt_e; else 01 if W matches; else 00. M has priority.
- forward_ad/bd: 10 if M matches and mem_read_m=0; else 01 if FWD_W_TO_D and W matches; else 00.
- lwstall = mem_read_e & write_reg_e!=0 & ((uses_rs_d & rs_d==write_reg_e) | (uses_rt_d & rt_d==write_reg_e)).
- brstall = branch_d & (E matches a used D source | (mem_read_m & M matches a used D source)).
- histall = hilo_read_d & (state!=IDLE | mdu_start_e).
- MDU FSM states: IDLE, BUSY, DONE. Counter cnt is CNT_W bits.
  - IDLE -> BUSY when mdu_start_e=1 and mdu_cancel=0; cnt <= (mdu_div_e ? DIV_LAT : MUL_LAT) - 1.
  - BUSY: if cnt==0 go to DONE, else cnt <= cnt-1.
  - DONE -> IDLE unconditionally. mdu_start_e is ignored in DONE, because that instruction advances this cycle.
  - mdu_cancel in any state: next state IDLE, cnt <= 0. Cancel has priority over start.
- mdu_stall = (state==IDLE & mdu_start_e & ~mdu_cancel) | state==BUSY.
  - An MDU op therefore occupies E for LAT+2 cycles, with stall_e high for LAT+1 of them.
- Stall and flush outputs:
  - stall_e = mdu_stall.
  - stall_f = stall_d = lwstall | brstall | histall | mdu_stall.
  - flush_e = (lwstall | brstall | histall) & ~stall_e. Never flush a held E.
  - flush_d = (pcsrc_d | jump_d) & ~stall_d. A redirect is only acted on when D advances.
- mdu_busy = (state!=IDLE). mdu_done = (state==DONE).
- Reset (resetn=0 at a clk edge):
  - state IDLE, cnt 0, mdu_busy 0, mdu_done 0.
  - Combinational outputs follow their inputs, but mdu_stall is forced 0 during reset.
  - Reset mid-BUSY aborts the operation with no mdu_done.
- Simultaneous events:
  - lwstall and a taken branch in the same cycle: stall wins, flush_d=0.
  - mdu_stall with lwstall: flush_e suppressed.
  - Source index 0 never matches and never stalls.

Decomposition:
- Shared package (mycpu_pkg): forward-select encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10; MDU state encoding; REG_AW default.
- One natural sub-module: mdu_sequencer, containing the FSM, cnt, mdu_stall, mdu_busy and mdu_done. The remainder is combinational in hazard_scoreboard.

Test Plan:
- lw $2 in E, D reads rs=2 with uses_rs_d=1 -> stall_f=stall_d=1, flush_e=1 for 1 cycle. Same with uses_rs_d=0 -> no stall.
- Branch in D using rs=3; cycle 0: lw $3 in E; cycle 1: lw $3 in M -> brstall for 2 consecutive cycles; cycle 2: forward_ad=01 (FWD_W_TO_D=1).
- mult with MUL_LAT=4 -> stall_e high exactly 5 cycles, mdu_done pulses on cycle 6, mdu_busy high for cycles 2-6. div with DIV_LAT=32 -> stall_e high 33 cycles.
- mfhi enters D while MDU BUSY -> stall_d held through DONE, released the cycle after.
- mdu_cancel or resetn=0 at BUSY cnt=10 -> next cycle IDLE, stall_e=0, no mdu_done.
- M and W both write $5, rs_e=5 -> forward_ae=10. With write_reg_m=0 and write_reg_w=0, rs_e=0 -> 00. Taken branch during lwstall -> flush_d=0.
